convolve_nx: RTL

Parametrised multi-channel 2-D convolution engine, next generation of the single-kernel dual-window convolver. It loads a KERNEL_SIZE×KERNEL_SIZE kernel once, then convolves NUM_WINDOWS windows in parallel against it, one MAC per lane per cycle. Results are shifted, saturated and returned with a valid pulse. It sits between the kernel SRAM / window line-buffer SRAMs and the NPU result writer, and adds kernel reuse across consecutive windows.

---
 rtl/convolve_nx_pkg.sv | 34 +++
 rtl/convolve_nx_mac_lane.sv | 70 +++++++
 rtl/convolve_nx.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/convolve_nx_pkg.sv
// Shared types and arithmetic helpers for the convolve_nx engine.
// Optional feature macro: CONVOLVE_NX_SIGNED_EN (two's-complement datapath).
package convolve_nx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_KERNEL,
    S_LOAD_WINDOWS,
    S_CALC,
    S_DONE
  } state_e;

  // Smallest accumulator that cannot wrap: full product width plus carry growth over K2 taps.
  function automatic int unsigned acc_width_min(input int unsigned dw, input int unsigned k2);
    return 2 * dw + $clog2(k2);
  endfunction

  function automatic logic [63:0] sat_unsigned(input logic [63:0] v, input int unsigned dw);
    logic [63:0] max_v;
    max_v = (64'd1 << dw) - 64'd1;
    return (v > max_v) ? max_v : v;
  endfunction

  function automatic logic [63:0] sat_signed(input logic signed [63:0] v, input int unsigned dw);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (dw - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (dw - 1));
    if (v > max_v) return max_v;
    if (v < min_v) return min_v;
    return v;
  endfunction

endpackage

// File: rtl/convolve_nx_mac_lane.sv
// One window lane: tap register file, multiply-accumulate, shift and saturate.
// Optional feature macro: CONVOLVE_NX_SIGNED_EN (signed product, arithmetic shift, signed clamp).
module mac_lane
  import convolve_nx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned K2         = 9,
  parameter int unsigned IDX_W      = 4,
  parameter int unsigned ACC_WIDTH  = 20,
  parameter int unsigned SHIFT      = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_win_we,
  input  logic [IDX_W-1:0]      i_win_idx,
  input  logic [DATA_WIDTH-1:0] i_win_data,
  input  logic                  i_clear,
  input  logic                  i_mac_en,
  input  logic [IDX_W-1:0]      i_tap,
  input  logic [DATA_WIDTH-1:0] i_kern,
  input  logic                  i_done,
  output logic [DATA_WIDTH-1:0] o_result
);

  logic [DATA_WIDTH-1:0] r_win [K2];
  logic [ACC_WIDTH-1:0]  r_acc;
  logic [DATA_WIDTH-1:0] r_result;

  logic [DATA_WIDTH-1:0] w_win_tap;
  logic [ACC_WIDTH-1:0]  w_prod_ext;
  logic [DATA_WIDTH-1:0] w_sat;

  assign w_win_tap = r_win[i_tap];

`ifdef CONVOLVE_NX_SIGNED_EN
  logic signed [2*DATA_WIDTH-1:0] w_prod;
  logic signed [ACC_WIDTH-1:0]    w_shifted;

  assign w_prod     = (2*DATA_WIDTH)'($signed(w_win_tap)) * (2*DATA_WIDTH)'($signed(i_kern));
  assign w_prod_ext = ACC_WIDTH'(w_prod);
  assign w_shifted  = $signed(r_acc) >>> SHIFT;
  assign w_sat      = DATA_WIDTH'(sat_signed(64'(w_shifted), DATA_WIDTH));
`else
  logic [2*DATA_WIDTH-1:0] w_prod;
  logic [ACC_WIDTH-1:0]    w_shifted;

  assign w_prod     = (2*DATA_WIDTH)'(w_win_tap) * (2*DATA_WIDTH)'(i_kern);
  assign w_prod_ext = ACC_WIDTH'(w_prod);
  assign w_shifted  = r_acc >> SHIFT;
  assign w_sat      = DATA_WIDTH'(sat_unsigned(64'(w_shifted), DATA_WIDTH));
`endif

  always_ff @(posedge i_clk) begin
    if (i_win_we) r_win[i_win_idx] <= i_win_data;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_acc    <= '0;
      r_result <= '0;
    end else begin
      if (i_clear)       r_acc <= '0;
      else if (i_mac_en) r_acc <= r_acc + w_prod_ext;
      if (i_done)        r_result <= w_sat;
    end
  end

  assign o_result = r_result;

endmodule

// File: rtl/convolve_nx.sv
// Multi-lane 2-D convolution engine: kernel store, sequencing FSM and NUM_WINDOWS mac_lane instances.
// Optional feature macro: CONVOLVE_NX_SIGNED_EN (two's-complement data, kernel and accumulator).
module convolve_nx
  import convolve_nx_pkg::*;
#(
  parameter int unsigned KERNEL_SIZE     = 3,
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned NUM_WINDOWS     = 2,
  parameter int unsigned SRAM_ADDR_WIDTH = 4,
  parameter int unsigned KADDR_WIDTH     = 6,
  parameter int unsigned ACC_WIDTH       = 20,
  parameter int unsigned SHIFT           = 0
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_start,
  input  logic                              i_reuse_kernel,
  output logic                              o_busy,
  output logic [KADDR_WIDTH-1:0]            o_kernel_addr,
  input  logic [DATA_WIDTH-1:0]             i_kernel_data,
  output logic [SRAM_ADDR_WIDTH-1:0]        o_window_addr,
  input  logic [NUM_WINDOWS*DATA_WIDTH-1:0] i_window_data,
  output logic [NUM_WINDOWS*DATA_WIDTH-1:0] o_result,
  output logic                              o_valid
);

  localparam int unsigned K2    = KERNEL_SIZE * KERNEL_SIZE;
  localparam int unsigned CNT_W = $clog2(K2 + 1);
  localparam logic [CNT_W-1:0] LAST_LOAD = CNT_W'(K2);
  localparam logic [CNT_W-1:0] LAST_TAP  = CNT_W'(K2 - 1);

  if (ACC_WIDTH < acc_width_min(DATA_WIDTH, K2)) begin : g_acc_width_check
    $error("convolve_nx: ACC_WIDTH too narrow for DATA_WIDTH and KERNEL_SIZE");
  end

  state_e                r_state;
  state_e                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  r_kernel_valid;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_kernel [K2];

  logic [CNT_W-1:0]      w_cap_idx;
  logic [CNT_W-1:0]      w_tap;
  logic                  w_win_we;
  logic                  w_clear;
  logic                  w_mac_en;
  logic                  w_done;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (i_start)
          w_state_nxt = (i_reuse_kernel && r_kernel_valid) ? S_LOAD_WINDOWS : S_LOAD_KERNEL;
      end
      S_LOAD_KERNEL: begin
        if (r_cnt == LAST_LOAD) begin
          w_state_nxt = S_LOAD_WINDOWS;
          w_cnt_nxt   = '0;
        end
      end
      S_LOAD_WINDOWS: begin
        if (r_cnt == LAST_LOAD) begin
          w_state_nxt = S_CALC;
          w_cnt_nxt   = '0;
        end
      end
      S_CALC: begin
        if (r_cnt == LAST_TAP) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = '0;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_kernel_valid <= 1'b0;
      r_valid        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= (r_state == S_DONE);
      if (r_state == S_LOAD_KERNEL && r_cnt == LAST_LOAD) r_kernel_valid <= 1'b1;
    end
  end

  // SRAM data lags its address by one cycle, so count value c captures tap c-1.
  assign w_cap_idx = r_cnt - CNT_W'(1);
  assign w_tap     = (r_cnt < LAST_LOAD) ? r_cnt : '0;

  always_ff @(posedge i_clk) begin
    if (r_state == S_LOAD_KERNEL && r_cnt != '0) r_kernel[w_cap_idx] <= i_kernel_data;
  end

  assign w_win_we = (r_state == S_LOAD_WINDOWS) && (r_cnt != '0);
  assign w_clear  = (r_state == S_LOAD_WINDOWS) && (r_cnt == LAST_LOAD);
  assign w_mac_en = (r_state == S_CALC);
  assign w_done   = (r_state == S_DONE);

  assign o_busy        = (r_state != S_IDLE);
  assign o_valid       = r_valid;
  assign o_kernel_addr = (r_state == S_LOAD_KERNEL && r_cnt < LAST_LOAD) ? KADDR_WIDTH'(r_cnt) : '0;
  assign o_window_addr = (r_state == S_LOAD_WINDOWS && r_cnt < LAST_LOAD) ? SRAM_ADDR_WIDTH'(r_cnt) : '0;

  for (genvar n = 0; n < NUM_WINDOWS; n++) begin : g_lane
    mac_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .K2         (K2),
      .IDX_W      (CNT_W),
      .ACC_WIDTH  (ACC_WIDTH),
      .SHIFT      (SHIFT)
    ) u_lane (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_win_we   (w_win_we),
      .i_win_idx  (w_cap_idx),
      .i_win_data (i_window_data[n*DATA_WIDTH +: DATA_WIDTH]),
      .i_clear    (w_clear),
      .i_mac_en   (w_mac_en),
      .i_tap      (w_tap),
      .i_kern     (r_kernel[w_tap]),
      .i_done     (w_done),
      .o_result   (o_result[n*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule
